ri5cy_to_ahb: RTL and testbench

RI5CY_TO_AHB -- requirements
Module: ri5cy_to_ahb

---
 rtl/ri5cy_to_ahb_if.sv | 40 ++++
 rtl/ri5cy_to_ahb.sv | 84 ++++++++
 tb/tb_ri5cy_to_ahb.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ri5cy_to_ahb_if.sv
// Signal bundle between a RI5CY-style data port and an AHB-Lite master bridge.
// Modport master is the bridge view; slave is the core-plus-bus environment view.
interface ri5cy_to_ahb_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
);
    logic                      req_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic                      we_i;
    logic [3:0]                be_i;
    logic [31:0]               addr_i;
    logic [31:0]               wdata_i;
    logic [31:0]               rdata_o;
    logic                      err_o;

    logic [AHB_ADDR_WIDTH-1:0] haddr_o;
    logic [AHB_DATA_WIDTH-1:0] hwdata_o;
    logic                      hwrite_o;
    logic [2:0]                hsize_o;
    logic [2:0]                hburst_o;
    logic [3:0]                hprot_o;
    logic [1:0]                htrans_o;
    logic                      hmastlock_o;
    logic [AHB_DATA_WIDTH-1:0] hrdata_i;
    logic                      hready_i;
    logic                      hresp_i;

    modport master (
        input  req_i, we_i, be_i, addr_i, wdata_i, hrdata_i, hready_i, hresp_i,
        output gnt_o, rvalid_o, rdata_o, err_o, haddr_o, hwdata_o, hwrite_o,
               hsize_o, hburst_o, hprot_o, htrans_o, hmastlock_o
    );

    modport slave (
        output req_i, we_i, be_i, addr_i, wdata_i, hrdata_i, hready_i, hresp_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, haddr_o, hwdata_o, hwrite_o,
               hsize_o, hburst_o, hprot_o, htrans_o, hmastlock_o
    );
endinterface

// File: rtl/ri5cy_to_ahb.sv
// RI5CY data port to AHB-Lite single-transfer master, one outstanding data phase.
// Define RI5CY_TO_AHB_ERR_EN to honour hresp_i (cancel next transfer, report err_o).
module ri5cy_to_ahb #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            rstn,
    ri5cy_to_ahb_if.master bus
);
    typedef enum logic {IDLE, DATA} state_t;

    state_t                    state;
    logic [AHB_DATA_WIDTH-1:0] hwdata_q;
    logic [31:0]               rdata_q;
    logic                      rvalid_q;
    logic                      err_q;
    logic [2:0]                be_cnt;
    logic [2:0]                hsize;
    logic                      cancel;
    logic                      resp_err;
    logic                      issue;
    logic                      dphase_done;

`ifdef RI5CY_TO_AHB_ERR_EN
    // First cycle of an error response must not start a new address phase.
    assign cancel   = (state == DATA) & bus.hresp_i;
    assign resp_err = bus.hresp_i;
`else
    logic unused_hresp;
    assign unused_hresp = bus.hresp_i;
    assign cancel       = 1'b0;
    assign resp_err     = 1'b0;
`endif

    assign be_cnt = 3'(bus.be_i[0]) + 3'(bus.be_i[1]) + 3'(bus.be_i[2]) + 3'(bus.be_i[3]);

    always_comb begin
        hsize = 3'b010;
        case (be_cnt)
            3'd1:    hsize = 3'b000;
            3'd2:    hsize = 3'b001;
            default: hsize = 3'b010;
        endcase
    end

    assign issue       = rstn & bus.req_i & bus.hready_i & ~cancel;
    assign dphase_done = (state == DATA) & bus.hready_i;

    assign bus.gnt_o       = issue;
    assign bus.htrans_o    = (rstn & bus.req_i & ~cancel) ? 2'b10 : 2'b00;
    assign bus.haddr_o     = AHB_ADDR_WIDTH'(bus.addr_i);
    assign bus.hwrite_o    = bus.we_i;
    assign bus.hsize_o     = hsize;
    assign bus.hburst_o    = 3'b000;
    assign bus.hprot_o     = 4'b0011;
    assign bus.hmastlock_o = 1'b0;
    assign bus.hwdata_o    = hwdata_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.rvalid_o    = rvalid_q;
    assign bus.err_o       = err_q;

    // A grant during data-phase completion overlaps the next address phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            hwdata_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= dphase_done;
            err_q    <= dphase_done & resp_err;
            if (dphase_done)
                rdata_q <= 32'(bus.hrdata_i);
            if (issue) begin
                state    <= DATA;
                hwdata_q <= AHB_DATA_WIDTH'(bus.wdata_i);
            end else if (dphase_done) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ri5cy_to_ahb.sv
// Randomized scoreboard bench for ri5cy_to_ahb: memory-level reference model,
// behavioural AHB slave with wait states, plus directed timing scenarios.
module tb_ri5cy_to_ahb;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ri5cy_to_ahb_if bus ();
    ri5cy_to_ahb dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] smem    [int unsigned];
    int          wait_min = 0;
    int          wait_max = 0;
    bit          inject_err = 1'b0;
    bit          dp_cur = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        smem[a >> 2]    = d;
        ref_mem[a >> 2] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit w, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_i   = r;
        bus.we_i    = w;
        bus.be_i    = be;
        bus.addr_i  = a;
        bus.wdata_i = wd;
    endtask

    function automatic logic [2:0] size_of(input logic [3:0] be);
        if ($countones(be) == 1) return 3'b000;
        if ($countones(be) == 2) return 3'b001;
        return 3'b010;
    endfunction

    // Behavioural AHB slave: memory, random wait states, optional error response.
    initial begin : slave
        bit          dp_valid, dp_write, dp_err;
        logic [31:0] dp_addr, w;
        logic [2:0]  dp_size;
        logic [3:0]  lanes;
        int          dp_wait, err_phase;
        int unsigned k;
        dp_valid = 0; dp_write = 0; dp_err = 0; dp_wait = 0; err_phase = 0;
        dp_addr = 0; dp_size = 0;
        bus.hready_i = 1'b1;
        bus.hresp_i  = 1'b0;
        bus.hrdata_i = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                dp_valid = 0;
                err_phase = 0;
            end else if (bus.hready_i) begin
                if (dp_valid && dp_write) begin
                    k = dp_addr >> 2;
                    w = smem.exists(k) ? smem[k] : 32'h0;
                    case (dp_size)
                        3'b000:  lanes = 4'b0001 << dp_addr[1:0];
                        3'b001:  lanes = 4'b0011 << {dp_addr[1], 1'b0};
                        default: lanes = 4'hF;
                    endcase
                    for (int b = 0; b < 4; b++)
                        if (lanes[b]) w[8*b +: 8] = bus.hwdata_o[8*b +: 8];
                    smem[k] = w;
                end
                dp_valid = 0;
                if (bus.htrans_o == 2'b10) begin
                    dp_valid  = 1;
                    dp_addr   = bus.haddr_o;
                    dp_write  = bus.hwrite_o;
                    dp_size   = bus.hsize_o;
                    dp_err    = inject_err;
                    err_phase = 0;
                    dp_wait   = $urandom_range(wait_max, wait_min);
                end
            end
            @(posedge clk);
            #1;
            dp_cur = dp_valid;
            if (dp_valid && dp_err && err_phase == 0) begin
                bus.hready_i = 1'b0; bus.hresp_i = 1'b1; err_phase = 1;
            end else if (dp_valid && dp_err) begin
                bus.hready_i = 1'b1; bus.hresp_i = 1'b1;
            end else begin
                if (dp_valid && dp_wait > 0) begin
                    bus.hready_i = 1'b0;
                    dp_wait--;
                end else begin
                    bus.hready_i = 1'b1;
                end
`ifdef RI5CY_TO_AHB_ERR_EN
                bus.hresp_i = 1'b0;
`else
                bus.hresp_i = 1'($urandom_range(1, 0));
`endif
            end
            if (!dp_valid)     bus.hrdata_i = $urandom;
            else if (dp_write) bus.hrdata_i = 32'hC0DE_0000 ^ dp_addr;
            else               bus.hrdata_i = smem.exists(dp_addr >> 2) ? smem[dp_addr >> 2] : 32'h0;
        end
    end

    // Issue side: every grant pushes the response the memory model predicts.
    initial begin : tracker
        exp_t        e;
        logic [31:0] w;
        int unsigned k;
        forever begin
            @(negedge clk);
            if (rstn && bus.gnt_o) begin
                k = bus.addr_i >> 2;
                e.err = inject_err;
                if (bus.we_i) begin
                    w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (bus.be_i[b]) w[8*b +: 8] = bus.wdata_i[8*b +: 8];
                    ref_mem[k] = w;
                    e.rdata = 32'hC0DE_0000 ^ bus.addr_i;
                end else begin
                    e.rdata = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
                end
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: per-cycle protocol rules and in-order response scoreboard.
    initial begin : monitor
        exp_t        e;
        logic        blk;
        logic        prev_dp, prev_hready;
        logic [31:0] prev_hwdata, last_rdata;
        prev_dp = 0; prev_hready = 1; prev_hwdata = 0; last_rdata = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_dp = 0;
                last_rdata = 0;
            end else begin
`ifdef RI5CY_TO_AHB_ERR_EN
                blk = dp_cur && bus.hresp_i;
`else
                blk = 1'b0;
                chk("err_tied_low", bus.err_o, 1'b0);
`endif
                chk("gnt_rule", bus.gnt_o, bus.req_i && bus.hready_i && !blk);
                chk("htrans_rule", bus.htrans_o, (bus.req_i && !blk) ? 2'b10 : 2'b00);
                chk("const_ctrl", {bus.hburst_o, bus.hprot_o, bus.hmastlock_o}, {3'b000, 4'b0011, 1'b0});
                chk("addr_we_pass", {bus.haddr_o, bus.hwrite_o}, {bus.addr_i, bus.we_i});
                chk("hsize_map", bus.hsize_o, size_of(bus.be_i));
                if (prev_dp && !prev_hready)
                    chk("hwdata_hold", bus.hwdata_o, prev_hwdata);
                if (bus.rvalid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("rvalid_unexpected", bus.rvalid_o, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_rdata", bus.rdata_o, e.rdata);
                        chk("sb_err", bus.err_o, e.err);
                        last_rdata = e.rdata;
                    end
                end else begin
                    chk("rdata_hold", bus.rdata_o, last_rdata);
                end
                prev_dp     = dp_cur;
                prev_hready = bus.hready_i;
                prev_hwdata = bus.hwdata_o;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            step();
            drive(0, 0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
        end
        step();
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin : main
        logic [31:0] pre [3];
        logic [31:0] a;
        logic [3:0]  be;
        int          sz, off, waited;
        pre[0] = 32'hA0A0_0A0A; pre[1] = 32'hB1B1_1B1B; pre[2] = 32'hC2C2_2C2C;
        preload(32'h1000, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) preload(32'(4 * i), pre[i]);
        preload(32'h40, 32'h4040_4040);
        preload(32'h44, 32'h4444_4444);
        #1 drive(1, 1, 4'hF, 32'h10, 32'h5555_AAAA);
        #6;
        chk("rst_gnt", bus.gnt_o, 1'b0);
        chk("rst_htrans", bus.htrans_o, 2'b00);
        chk("rst_rvalid", bus.rvalid_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_rdata", bus.rdata_o, 32'h0);
        chk("rst_hwdata", bus.hwdata_o, 32'h0);
        step();
        rstn = 1'b1;
        drive(0, 0, 4'h0, 32'h0, 32'h0);

        // single word read
        step(); drive(1, 0, 4'hF, 32'h1000, 32'h0); @(negedge clk);
        chk("rd_gnt_c0", bus.gnt_o, 1'b1);
        chk("rd_htrans_c0", bus.htrans_o, 2'b10);
        chk("rd_hsize_c0", bus.hsize_o, 3'b010);
        step(); drive(0, 0, 4'h0, 32'h0, 32'h0); @(negedge clk);
        step(); @(negedge clk);
        chk("rd_rvalid_c2", bus.rvalid_o, 1'b1);
        chk("rd_rdata_c2", bus.rdata_o, 32'hDEAD_BEEF);

        // byte write
        step(); drive(1, 1, 4'b0100, 32'h2002, 32'h00AB_0000); @(negedge clk);
        chk("bw_gnt_c0", bus.gnt_o, 1'b1);
        chk("bw_hsize_c0", bus.hsize_o, 3'b000);
        chk("bw_haddr_c0", bus.haddr_o, 32'h2002);
        step(); drive(0, 0, 4'h0, 32'h0, 32'h0); @(negedge clk);
        chk("bw_hwdata_c1", bus.hwdata_o, 32'h00AB_0000);
        step(); @(negedge clk);
        chk("bw_rvalid_c2", bus.rvalid_o, 1'b1);

        // three back-to-back reads
        for (int c = 0; c < 6; c++) begin
            step(); drive(c < 3, 0, 4'hF, 32'(4 * c), 32'h0); @(negedge clk);
            chk("b2b_gnt", bus.gnt_o, c < 3);
            chk("b2b_rvalid", bus.rvalid_o, c >= 2 && c < 5);
            if (c >= 2 && c < 5) chk("b2b_rdata", bus.rdata_o, pre[c-2]);
        end

        // two wait states with the next request pending
        wait_min = 2; wait_max = 2;
        step(); drive(1, 1, 4'hF, 32'h30, 32'h1234_5678); @(negedge clk);
        chk("ws_gnt_c0", bus.gnt_o, 1'b1);
        step(); drive(1, 0, 4'hF, 32'h34, 32'h0); wait_min = 0; wait_max = 0;
        for (int c = 1; c < 3; c++) begin
            if (c > 1) step();
            @(negedge clk);
            chk("ws_gnt_wait", bus.gnt_o, 1'b0);
            chk("ws_htrans_wait", bus.htrans_o, 2'b10);
            chk("ws_hwdata_wait", bus.hwdata_o, 32'h1234_5678);
        end
        step(); @(negedge clk);
        chk("ws_gnt_c3", bus.gnt_o, 1'b1);
        step(); drive(0, 0, 4'h0, 32'h0, 32'h0); @(negedge clk);
        chk("ws_rvalid_c4", bus.rvalid_o, 1'b1);
        drain();

`ifdef RI5CY_TO_AHB_ERR_EN
        step(); inject_err = 1'b1; drive(1, 0, 4'hF, 32'h40, 32'h0); @(negedge clk);
        chk("er_gnt_c0", bus.gnt_o, 1'b1);
        step(); inject_err = 1'b0; drive(1, 0, 4'hF, 32'h44, 32'h0);
        for (int c = 1; c < 3; c++) begin
            if (c > 1) step();
            @(negedge clk);
            chk("er_htrans_idle", bus.htrans_o, 2'b00);
            chk("er_gnt_low", bus.gnt_o, 1'b0);
        end
        step(); @(negedge clk);
        chk("er_gnt_after", bus.gnt_o, 1'b1);
        chk("er_rvalid", bus.rvalid_o, 1'b1);
        chk("er_err", bus.err_o, 1'b1);
        drain();
`endif

        // reset during a stalled data phase
        wait_min = 5; wait_max = 5;
        step(); drive(1, 0, 4'hF, 32'h50, 32'hFFFF_FFFF); @(negedge clk);
        chk("rm_gnt_c0", bus.gnt_o, 1'b1);
        step(); drive(1, 0, 4'hF, 32'h54, 32'hFFFF_FFFF); @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rm_gnt", bus.gnt_o, 1'b0);
        chk("rm_htrans", bus.htrans_o, 2'b00);
        chk("rm_rvalid", bus.rvalid_o, 1'b0);
        chk("rm_err", bus.err_o, 1'b0);
        chk("rm_rdata", bus.rdata_o, 32'h0);
        chk("rm_hwdata", bus.hwdata_o, 32'h0);
        exp_q.delete();
        wait_min = 0; wait_max = 0;
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        repeat (2) step();
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rm_no_rvalid", bus.rvalid_o, 1'b0);
        end

        // randomized traffic
        wait_min = 0; wait_max = 2;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                step();
                drive(0, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), $urandom, $urandom);
                @(negedge clk);
            end else begin
                sz  = $urandom_range(2, 0);
                off = (sz == 0) ? $urandom_range(3, 0) : (sz == 1) ? 2 * $urandom_range(1, 0) : 0;
                be  = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'hF;
                a   = 32'h100 + 32'(4 * $urandom_range(31, 0)) + 32'(off);
                step();
                drive(1, 1'($urandom_range(1, 0)), be, a, $urandom);
                @(negedge clk);
                waited = 0;
                while (!bus.gnt_o && waited < 30) begin
                    waited++;
                    step();
                    @(negedge clk);
                end
                if (!bus.gnt_o) chk("grant_timeout", bus.gnt_o, 1'b1);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
